// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin arbiter and its data select.
//   ST_IDLE / ST_BURST : arbiter state encoding
//   DATA_W_DEF         : default data channel width
//   BURST_LEN_DEF      : default maximum beats per grant
package mux_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } st_e;

    localparam int DATA_W_DEF    = 8;
    localparam int BURST_LEN_DEF = 4;

endpackage

// File: rtl/mux_2_1.sv
// Single-bit 2:1 selector.
//   in_i[1:0] : candidate bits, in_i[0] chosen when s_i=0
//   s_i       : select
//   y_o       : selected bit
module mux_2_1 (
    input  logic [1:0] in_i,
    input  logic       s_i,
    output logic       y_o
);

    assign y_o = s_i ? in_i[1] : in_i[0];

endmodule

// File: rtl/rr_arb_2_1.sv
// Two-source round-robin arbiter with a registered valid/ready output stage.
// A source is granted for a burst of up to BURST_LEN beats; its data is
// steered through a bank of mux_2_1 cells and captured in the output register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid[1:0]        : per-source valid (bit 0 = source 0)
//   in0_data, in1_data   : source data
//   in_ready[1:0]        : per-source ready, at most one bit high
//   out_data, out_valid  : registered output beat
//   out_ready            : downstream accept
//   sel                  : current grant
module rr_arb_2_1
    import mux_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int CNT_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        in_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [DATA_W-1:0] in1_data,
    output logic [1:0]        in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sel
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    st_e               st_q, st_d;
    logic              g_q, g_d;
    logic              lst_q, lst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        in_ready_s;
    logic              room_s;
    logic              load_s;
    logic [DATA_W-1:0] sel_data_s;

    // The output register can take a beat when empty or draining this cycle.
    assign room_s = !out_valid_q || out_ready;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        mux_2_1 u_mux (
            .in_i ({in1_data[i], in0_data[i]}),
            .s_i  (g_q),
            .y_o  (sel_data_s[i])
        );
    end

    // Arbiter next-state: grant selection, burst counting and release.
    always_comb begin
        st_d       = st_q;
        g_d        = g_q;
        lst_d      = lst_q;
        cnt_d      = cnt_q;
        load_s     = 1'b0;
        in_ready_s = 2'b00;
        case (st_q)
            ST_IDLE: begin
                if (in_valid != 2'b00) begin
                    // On a tie the source not served last wins.
                    if (in_valid == 2'b11) begin
                        g_d = ~lst_q;
                    end else begin
                        g_d = in_valid[1];
                    end
                    cnt_d = CNT_ZERO;
                    st_d  = ST_BURST;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                in_ready_s = g_q ? {room_s, 1'b0} : {1'b0, room_s};
                if (!in_valid[g_q]) begin
                    // Granted source went quiet: release without a transfer.
                    lst_d = g_q;
                    cnt_d = CNT_ZERO;
                    st_d  = ST_IDLE;
                end else if (room_s) begin
                    load_s = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        lst_d = g_q;
                        cnt_d = CNT_ZERO;
                        st_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    st_d = ST_BURST;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Output register next-state: load wins over drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, grant, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            g_q         <= 1'b0;
            lst_q       <= 1'b1;
            cnt_q       <= CNT_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            st_q        <= st_d;
            g_q         <= g_d;
            lst_q       <= lst_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // in_ready must follow out_ready within the cycle, so it stays combinational.
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = g_q;

endmodule

// File: tb/tb_rr_arb_2_1.sv
module tb_rr_arb_2_1;

    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 2;

    logic              clk;
    logic              rst_n;
    logic [1:0]        in_valid;
    logic [DATA_W-1:0] in0_data;
    logic [DATA_W-1:0] in1_data;
    logic [1:0]        in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              sel;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arb_2_1 #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in0_data  (in0_data),
        .in1_data  (in1_data),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the link, how many beats it has sent,
    // who was served last, and what sits in the output slot.
    bit              m_busy  = 1'b0;
    bit              m_owner = 1'b0;
    bit              m_last  = 1'b1;
    int              m_beats = 0;
    bit              m_ov    = 1'b0;
    logic [DATA_W-1:0] m_od  = '0;

    always @(negedge clk) begin
        logic [1:0] er;
        bit room, take;
        if (!rst_n) begin
            m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_beats = 0;
            m_ov = 1'b0; m_od = '0;
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", {24'd0, out_data}, 32'd0);
            chk("rst_sel", {31'd0, sel}, 32'd0);
            chk("rst_in_ready", {30'd0, in_ready}, 32'd0);
        end else begin
            room = !m_ov || out_ready;
            er = (m_busy && room) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("mdl_sel", {31'd0, sel}, {31'd0, m_owner});
            chk("mdl_in_ready", {30'd0, in_ready}, {30'd0, er});
            chk("mdl_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            if (m_ov) chk("mdl_out_data", {24'd0, out_data}, {24'd0, m_od});
            take = m_busy && room && in_valid[m_owner];
            if (take) begin
                m_od = m_owner ? in1_data : in0_data;
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (!m_busy) begin
                if (in_valid != 2'b00) begin
                    m_owner = (in_valid == 2'b11) ? !m_last : in_valid[1];
                    m_busy  = 1'b1;
                    m_beats = 0;
                end
            end else if (!in_valid[m_owner]) begin
                m_last = m_owner;
                m_busy = 1'b0;
            end else if (take) begin
                m_beats++;
                if (m_beats == BURST_LEN) begin
                    m_last = m_owner;
                    m_busy = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 2'b00;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] pat [14];
        logic [1:0] pv;
        pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10,
                2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        rst_n = 1'b0;
        in_valid = 2'b00;
        in0_data = '0;
        in1_data = '0;
        out_ready = 1'b1;
        step();

        // Single beat from source 0: two-cycle latency.
        do_reset();
        in_valid = 2'b01; in0_data = 8'hA5; in1_data = 8'h3C;
        step();
        chk("lat_sel_c1", {31'd0, sel}, 32'd0);
        chk("lat_ready_c1", {30'd0, in_ready}, 32'd1);
        step();
        chk("lat_valid_c2", {31'd0, out_valid}, 32'd1);
        chk("lat_data_c2", {24'd0, out_data}, 32'hA5);
        in_valid = 2'b00;
        repeat (3) step();

        // Both sources streaming: 4 / bubble / 4 / bubble / 4.
        do_reset();
        in_valid = 2'b11;
        for (int k = 0; k < 14; k++) begin
            in0_data = 8'($urandom); in1_data = 8'($urandom);
            step();
            chk("rr_ready_pattern", {30'd0, in_ready}, {30'd0, pat[k]});
        end
        in_valid = 2'b00;
        repeat (3) step();

        // Backpressure for three cycles after the first beat.
        do_reset();
        in_valid = 2'b01; in0_data = 8'h11;
        step();
        step();
        in0_data = 8'h22; out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", {30'd0, in_ready}, 32'd0);
            chk("bp_data", {24'd0, out_data}, 32'h11);
            step();
            in0_data = 8'h22 + 8'(k + 1);
        end
        out_ready = 1'b1;
        repeat (6) step();
        in_valid = 2'b00;
        repeat (3) step();

        // Source 1 drops after two beats while source 0 waits.
        do_reset();
        in_valid = 2'b10; in1_data = 8'h51;
        step();
        in1_data = 8'h52;
        step();
        step();
        in_valid = 2'b01; in0_data = 8'h60;
        step();
        chk("er_idle_ready", {30'd0, in_ready}, 32'd0);
        chk("er_idle_sel", {31'd0, sel}, 32'd1);
        step();
        chk("er_grant0_sel", {31'd0, sel}, 32'd0);
        chk("er_grant0_ready", {30'd0, in_ready}, 32'd1);
        in_valid = 2'b00;
        repeat (3) step();

        // Asynchronous reset mid-burst with a beat in flight.
        do_reset();
        in_valid = 2'b10; in1_data = 8'h77;
        step();
        step();
        chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_sel", {31'd0, sel}, 32'd0);
        chk("ar_ready", {30'd0, in_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        in_valid = 2'b11;
        step();
        chk("ar_tie_ready", {30'd0, in_ready}, 32'd1);
        in_valid = 2'b00;
        repeat (3) step();

        // Randomized traffic with occasional resets.
        pv = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) pv = 2'($urandom);
            in_valid  = pv;
            out_ready = ($urandom_range(0, 9) < 7);
            in0_data  = 8'($urandom);
            in1_data  = 8'($urandom);
            step();
        end
        rst_n = 1'b1;
        in_valid = 2'b00;
        out_ready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
